// File: rtl/ofmap_writeback.sv
// ofmap_writeback: packs the accelerator ofmap stream into DRAM words, queues them and writes them out.
// Build option: define OFMAP_WB_SAT_EN to saturate mode-0 results to 0..127 instead of truncating.
module ofmap_writeback #(
   parameter int DATA_SIZE  = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_BIT   = 12,
   parameter int BASE_ADDR  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic                 in_valid,
   input  logic [DATA_SIZE-1:0] in_data,
   input  logic                 in_done,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [DATA_SIZE-1:0] out_data,
   output logic [ADDR_BIT-1:0]  out_addr,
   output logic                 out_last,
   output logic                 overflow,
   output logic                 busy,
   output logic                 wb_done
);
   localparam int LANES  = DATA_SIZE / 8;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_FLUSH   = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   localparam logic [ADDR_BIT-1:0] BASE = ADDR_BIT'(BASE_ADDR);

   logic [1:0]           state_q, state_d;
   logic                 mode_q, mode_d;
   logic                 pend_q, pend_d;
   logic                 ovf_q, ovf_d;
   logic [LANE_W-1:0]    lane_q, lane_d;
   logic [DATA_SIZE-1:0] pack_q, pack_d;
   logic [ADDR_BIT-1:0]  addr_q, addr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];

   logic                 take, push, pop, full, wr_en, cur_mode;
   logic [DATA_SIZE-1:0] push_data, pack_with;
   logic [7:0]           byte_v;

`ifdef OFMAP_WB_SAT_EN
   always_comb begin
      byte_v = {1'b0, in_data[6:0]};
      if (in_data[DATA_SIZE-1]) begin
         byte_v = 8'h00;
      end else if (in_data[DATA_SIZE-2:7] != '0) begin
         byte_v = 8'h7F;
      end
   end
`else
   assign byte_v = {1'b0, in_data[6:0]};
`endif

   // Output handshake: a word transfers on a cycle where out_valid && out_ready; while out_valid
   // is high and out_ready low, out_data/out_addr/out_last hold. In COLLECT one word is held back
   // so the final word of the frame can still be tagged with out_last.
   assign full      = (count_q == CNT_W'(FIFO_DEPTH));
   assign out_valid = ((state_q == S_COLLECT) && (count_q >= CNT_W'(2))) ||
                      ((state_q == S_DRAIN) && (count_q != '0));
   assign out_last  = (state_q == S_DRAIN) && (count_q == CNT_W'(1));
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign out_addr  = addr_q;
   assign overflow  = ovf_q;
   assign busy      = (state_q != S_IDLE);

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      pend_d    = pend_q;
      ovf_d     = ovf_q;
      lane_d    = lane_q;
      pack_d    = pack_q;
      addr_d    = addr_q;
      take      = 1'b0;
      push      = 1'b0;
      push_data = pack_q;
      wb_done   = 1'b0;
      cur_mode  = (state_q == S_IDLE) ? mode : mode_q;
      pack_with = pack_q;
      pack_with[{lane_q, 3'b000} +: 8] = byte_v;

      case (state_q)
         S_IDLE: begin
            if (in_valid || in_done) begin
               state_d = S_COLLECT;
               mode_d  = mode;
               ovf_d   = 1'b0;
               addr_d  = BASE;
               take    = in_valid;
               pend_d  = in_done;
            end
         end
         S_COLLECT: begin
            // A done seen on the frame's first cycle is finished here without taking more input.
            if (pend_q) begin
               state_d = S_FLUSH;
               pend_d  = 1'b0;
            end else begin
               take = in_valid;
               if (in_done) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            state_d = S_DRAIN;
            if (lane_q != '0) begin
               push   = 1'b1;
               lane_d = '0;
               pack_d = '0;
            end else if (count_q == '0) begin
               wb_done = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            if (pop && out_last) begin
               wb_done = 1'b1;
               state_d = S_IDLE;
            end
         end
      endcase

      if (take) begin
         if (cur_mode) begin
            push      = 1'b1;
            push_data = in_data;
         end else if (lane_q == LANE_W'(LANES - 1)) begin
            push      = 1'b1;
            push_data = pack_with;
            pack_d    = '0;
            lane_d    = '0;
         end else begin
            pack_d = pack_with;
            lane_d = lane_q + LANE_W'(1);
         end
      end

      // A full FIFO still accepts a word when the head leaves in the same cycle.
      wr_en = push && (!full || pop);
      if (push && full && !pop) ovf_d = 1'b1;
      if (pop) addr_d = addr_q + ADDR_BIT'(1);

      wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (wr_en && !pop) count_d = count_q + CNT_W'(1);
      else if (!wr_en && pop) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mode_q   <= 1'b0;
         pend_q   <= 1'b0;
         ovf_q    <= 1'b0;
         lane_q   <= '0;
         pack_q   <= '0;
         addr_q   <= BASE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
         lane_q   <= lane_d;
         pack_q   <= pack_d;
         addr_q   <= addr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_data;
   end
endmodule
